// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Double-dabble digit correction: digits at or above the threshold get the offset
   localparam logic [3:0] ADJ_THRESH = 4'd5;
   localparam logic [3:0] ADJ_OFFSET = 4'd3;

   // Largest value representable in the given number of decimal digits (10^digits - 1)
   function automatic logic [63:0] max_bcd_value(input int digits);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational per-digit correction applied before each double-dabble shift.
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);

   // Add 3 to any digit of 5 or more so the following shift carries correctly
   always_comb begin
      d_o = d_i;
      if (d_i >= ADJ_THRESH) begin
         d_o = d_i + ADJ_OFFSET;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle,
// with saturating overflow and leading-zero blanking flags.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 5
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic [DIGITS-1:0]     blank
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int TOT_W = ACC_W + BIN_W;
   localparam logic [63:0]       MAX_VAL   = max_bcd_value(DIGITS);
   localparam logic [ACC_W-1:0]  NINES     = {DIGITS{4'h9}};
   localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [BIN_W-1:0]   sr_q, sr_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic [ACC_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;
   logic [DIGITS-1:0]  blank_q, blank_d;

   logic [ACC_W-1:0]   acc_adj;
   logic [TOT_W-1:0]   shifted;
   logic [ACC_W-1:0]   result;

   // blank[i] is set when digit i and every digit above it are zero; digit 0 always shows
   function automatic logic [DIGITS-1:0] blank_of(input logic [ACC_W-1:0] v);
      logic [DIGITS-1:0] b;
      logic              zero_above;
      b          = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (v[4*i +: 4] == 4'd0);
         b[i]       = zero_above;
      end
      return b;
   endfunction

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d_i (acc_q[4*g +: 4]),
         .d_o (acc_adj[4*g +: 4])
      );
   end

   // The last shift result feeds the output registers directly so they load on DONE entry
   assign shifted = {acc_adj, sr_q} << 1;
   assign result  = ovf_pend_q ? NINES : shifted[TOT_W-1:BIN_W];
   assign busy    = (state_q == SHIFT);
   assign done    = (state_q == DONE);
   assign bcd     = bcd_q;
   assign ovf     = ovf_q;
   assign blank   = blank_q;

   // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      sr_d       = sr_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      blank_d    = blank_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d       = bin;
               acc_d      = '0;
               cnt_d      = CNT_W'(BIN_W);
               ovf_pend_d = (64'(bin) > MAX_VAL);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = shifted[TOT_W-1:BIN_W];
            sr_d  = shifted[BIN_W-1:0];
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               bcd_d   = result;
               ovf_d   = ovf_pend_q;
               blank_d = ovf_pend_q ? '0 : blank_of(result);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers; reset takes priority over any start request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         sr_q       <= '0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         blank_q    <= BLANK_RST;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         sr_q       <= sr_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         blank_q    <= blank_d;
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 5-digit and a 4-digit instance
// compared against a decimal reference model.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [13:0] bin_a, bin_b;
   logic        busy_a, done_a, ovf_a;
   logic [19:0] bcd_a;
   logic [4:0]  blank_a;
   logic        busy_b, done_b, ovf_b;
   logic [15:0] bcd_b;
   logic [3:0]  blank_b;

   int checks = 0;
   int errors = 0;

   // Results captured by the conversion tasks
   int          r_lat, r_busy, r_done;
   logic [19:0] r_bcd;
   logic        r_ovf;
   logic [4:0]  r_blank;

   always #5 clk = ~clk;

   bin2bcd_seq #(.BIN_W(14), .DIGITS(5)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
      .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a), .blank(blank_a)
   );

   bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
      .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b), .blank(blank_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Reference: decimal digits by division, saturating to all nines when too large
   function automatic logic [19:0] ref_bcd(input int v, input int nd);
      logic [19:0] r = '0;
      int x = v;
      for (int i = 0; i < nd; i++) begin
         if (v > pow10(nd) - 1) r[4*i +: 4] = 4'd9;
         else begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
         end
      end
      return r;
   endfunction

   // Reference: digit i and above are zero exactly when v < 10^i
   function automatic logic [4:0] ref_blank(input int v, input int nd);
      logic [4:0] r = '0;
      if (v <= pow10(nd) - 1) begin
         for (int i = 1; i < nd; i++) r[i] = (v < pow10(i));
      end
      return r;
   endfunction

   task automatic convert_a(input logic [13:0] v, input bit spam, input int ncyc);
      bin_a   = v;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      r_lat = -1; r_busy = 0; r_done = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (busy_a) r_busy++;
         if (done_a) begin
            if (r_done == 0) begin
               r_lat = c; r_bcd = bcd_a; r_ovf = ovf_a; r_blank = blank_a;
            end
            r_done++;
         end
         if (spam && busy_a) begin
            start_a = 1'b1;
            bin_a   = 14'd9;
         end else begin
            start_a = 1'b0;
         end
         tick();
      end
      start_a = 1'b0;
   endtask

   task automatic convert_b(input logic [13:0] v, input int ncyc);
      bin_b   = v;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      r_lat = -1; r_busy = 0; r_done = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (busy_b) r_busy++;
         if (done_b) begin
            if (r_done == 0) begin
               r_lat = c; r_bcd = {4'h0, bcd_b}; r_ovf = ovf_b; r_blank = {1'b0, blank_b};
            end
            r_done++;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({busy_a, done_a, ovf_a} !== 3'b000 || bcd_a !== 20'h0 || blank_a !== 5'b11110) begin
         errors++;
         $display("FAIL reset_a busy=%b done=%b ovf=%b bcd=%h blank=%b want 0 0 0 00000 11110",
                  busy_a, done_a, ovf_a, bcd_a, blank_a);
      end
      checks++;
      if ({busy_b, done_b, ovf_b} !== 3'b000 || bcd_b !== 16'h0 || blank_b !== 4'b1110) begin
         errors++;
         $display("FAIL reset_b busy=%b done=%b ovf=%b bcd=%h blank=%b want 0 0 0 0000 1110",
                  busy_b, done_b, ovf_b, bcd_b, blank_b);
      end
   endtask

   task automatic test_zero();
      convert_a(14'd0, 1'b0, 20);
      checks++;
      if (r_lat !== 14) begin errors++; $display("FAIL zero_latency got %0d want 14", r_lat); end
      checks++;
      if (r_bcd !== 20'h00000 || r_ovf !== 1'b0 || r_blank !== 5'b11110) begin
         errors++;
         $display("FAIL zero_result bcd=%h ovf=%b blank=%b want 00000 0 11110", r_bcd, r_ovf, r_blank);
      end
   endtask

   task automatic test_max();
      convert_a(14'd16383, 1'b0, 20);
      checks++;
      if (r_busy !== 14) begin errors++; $display("FAIL max_busy_cycles got %0d want 14", r_busy); end
      checks++;
      if (r_bcd !== 20'h16383 || r_ovf !== 1'b0 || r_blank !== 5'b00000) begin
         errors++;
         $display("FAIL max_result bcd=%h ovf=%b blank=%b want 16383 0 00000", r_bcd, r_ovf, r_blank);
      end
      checks++;
      if (bcd_a !== 20'h16383) begin errors++; $display("FAIL max_hold bcd=%h want 16383", bcd_a); end
   endtask

   task automatic test_ignore_start();
      convert_a(14'd1234, 1'b1, 40);
      checks++;
      if (r_done !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", r_done); end
      checks++;
      if (r_bcd !== 20'h01234 || r_blank !== 5'b10000) begin
         errors++;
         $display("FAIL ignore_result bcd=%h blank=%b want 01234 10000", r_bcd, r_blank);
      end
      checks++;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL ignore_no_queue busy=%b want 0", busy_a); end
   endtask

   task automatic test_digits4();
      convert_b(14'd9999, 20);
      checks++;
      if (r_bcd[15:0] !== 16'h9999 || r_ovf !== 1'b0 || r_blank[3:0] !== 4'b0000) begin
         errors++;
         $display("FAIL d4_9999 bcd=%h ovf=%b blank=%b want 9999 0 0000", r_bcd[15:0], r_ovf, r_blank[3:0]);
      end
      convert_b(14'd10000, 20);
      checks++;
      if (r_bcd[15:0] !== 16'h9999 || r_ovf !== 1'b1 || r_blank[3:0] !== 4'b0000) begin
         errors++;
         $display("FAIL d4_10000 bcd=%h ovf=%b blank=%b want 9999 1 0000", r_bcd[15:0], r_ovf, r_blank[3:0]);
      end
      convert_b(14'd7, 20);
      checks++;
      if (r_bcd[15:0] !== 16'h0007 || r_ovf !== 1'b0 || r_blank[3:0] !== 4'b1110) begin
         errors++;
         $display("FAIL d4_7 bcd=%h ovf=%b blank=%b want 0007 0 1110", r_bcd[15:0], r_ovf, r_blank[3:0]);
      end
   endtask

   task automatic test_reset_mid();
      int seen_done = 0;
      int seen_busy = 0;
      bin_a   = 14'd4321;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      start_a = 1'b1;
      tick();
      rst = 1'b0;
      start_a = 1'b0;
      checks++;
      if ({busy_a, done_a, ovf_a} !== 3'b000 || bcd_a !== 20'h0 || blank_a !== 5'b11110) begin
         errors++;
         $display("FAIL midreset_state busy=%b done=%b ovf=%b bcd=%h blank=%b want 0 0 0 00000 11110",
                  busy_a, done_a, ovf_a, bcd_a, blank_a);
      end
      for (int i = 0; i < 20; i++) begin
         if (done_a) seen_done++;
         if (busy_a) seen_busy++;
         tick();
      end
      checks++;
      if (seen_done !== 0 || seen_busy !== 0) begin
         errors++;
         $display("FAIL midreset_quiet done_seen=%0d busy_seen=%0d want 0 0", seen_done, seen_busy);
      end
      convert_a(14'd4321, 1'b0, 20);
      checks++;
      if (r_bcd !== 20'h04321 || r_done !== 1) begin
         errors++;
         $display("FAIL midreset_restart bcd=%h done_count=%0d want 04321 1", r_bcd, r_done);
      end
   endtask

   task automatic test_random();
      int v;
      for (int n = 0; n < 1000; n++) begin
         v = $urandom_range(0, 16383);
         convert_a(14'(v), 1'b0, 17);
         checks++;
         if (r_done !== 1 || r_lat !== 14) begin
            errors++;
            $display("FAIL rand_a_handshake bin=%0d done_count=%0d latency=%0d want 1 14", v, r_done, r_lat);
         end
         checks++;
         if (r_bcd !== ref_bcd(v, 5) || r_ovf !== 1'b0 || r_blank !== ref_blank(v, 5)) begin
            errors++;
            $display("FAIL rand_a_value bin=%0d bcd=%h ovf=%b blank=%b want %h 0 %b",
                     v, r_bcd, r_ovf, r_blank, ref_bcd(v, 5), ref_blank(v, 5));
         end
      end
      for (int n = 0; n < 200; n++) begin
         v = $urandom_range(0, 16383);
         convert_b(14'(v), 17);
         checks++;
         if (r_done !== 1 || r_bcd[15:0] !== ref_bcd(v, 4)[15:0] || r_ovf !== (v > 9999)
             || r_blank[3:0] !== ref_blank(v, 4)[3:0]) begin
            errors++;
            $display("FAIL rand_b bin=%0d done_count=%0d bcd=%h ovf=%b blank=%b want 1 %h %b %b",
                     v, r_done, r_bcd[15:0], r_ovf, r_blank[3:0], ref_bcd(v, 4)[15:0],
                     (v > 9999), ref_blank(v, 4)[3:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_max();
      test_ignore_start();
      test_digits4();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
